seven_segment_counter_mux: RTL and testbench
============================================

Name: seven_segment_counter_mux

Overview:
- Parametrised multi-digit successor to the single-digit seconds display.
- Prescales `clk` to a count tick and holds an N-digit BCD counter that counts up or down, with synchronous load and wrap flag.
- Drives a time-multiplexed common-segment display: one shared 7-segment bus plus one-hot digit selects, with optional leading-zero blanking.
- Sits between the user-project clock/reset and the GPIO pads.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and digit-select lines (1..8).
- TICK_COUNT, 16000000, clk cycles per count step (>=2); prescaler width = clog2(TICK_COUNT).
- SCAN_COUNT, 1024, clk cycles each digit is displayed during scanning (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = prescaler runs and counts; 0 = prescaler and count freeze (scan continues).
- up_down  in  1  1 = count up, 0 = count down; sampled on each tick.
- load  in  1  one-cycle synchronous load strobe.
- load_value  in  4*NUM_DIGITS  BCD value loaded on `load`; digit 0 is in bits [3:0].
- blank_lz  in  1  1 = blank leading zeros.
- count_out  out  4*NUM_DIGITS  current BCD count, registered.
- wrap  out  1  one-cycle pulse when the count wraps.
- led_out  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable, registered.
- io_oeb  out  7+NUM_DIGITS  constant all zeros (all pads are outputs).

Behaviour:
- Reset values:
  - prescaler 0, count_out 0, wrap 0, scan counter 0, scan index 0.
  - digit_sel = 1 (digit 0 selected).
  - led_out = 7'b0111111 (glyph "0").
- Prescaler:
  - When en=1, it counts 0..TICK_COUNT-1 and then returns to 0.
  - The tick is asserted combinationally in the cycle the prescaler equals TICK_COUNT-1, giving a period of exactly TICK_COUNT cycles.
  - When en=0, the prescaler holds and no tick is generated.
- Count (per tick):
  - Up: digit 0 goes 9->0 with carry into the next digit; a digit only changes if all lower digits carry.
  - Down: 0->9 with borrow, using the same rule.
  - Wrap up: all 9s -> all 0s. Wrap down: all 0s -> all 9s.
  - On wrap, `wrap` is 1 for the cycle after the tick (registered alongside count_out).
  - count_out updates in the cycle after the tick edge (1-cycle latency).
- Load:
  - Has priority over the tick in the same cycle.
  - The next cycle, count_out = load_value and the prescaler = 0.
  - Any load_value digit >9 is loaded as 0.
  - wrap = 0 on a load cycle.
  - Load works regardless of en.
- Scan:
  - Free-running and independent of en and load.
  - The scan counter counts 0..SCAN_COUNT-1; at terminal count the scan index advances 0->1->...->NUM_DIGITS-1->0.
  - digit_sel = 1<<index; led_out = decode of count_out digit[index].
  - Both are registered in the same cycle, so they are always mutually consistent (no ghosting).
- Blanking:
  - When blank_lz=1, digit k (k>=1) is blanked (led_out=0) if it and every digit above it is 0.
  - Digit 0 is never blanked.
  - digit_sel still asserts for blanked digits.
- Decode glyphs:
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110.
  - 5:1101101, 6:1111100, 7:0000111, 8:1111111, 9:1100111.
  - Any other value decodes to 0000000.
- Reset mid-operation: all state returns to reset values on the next edge, including mid-scan and mid-prescale. Reset overrides load.
- NUM_DIGITS=1: scan index stays at 0 and digit_sel stays 1.

Decomposition:
- Shared package `seven_seg_pkg`:
  - Glyph constants SEG_0..SEG_9 and SEG_BLANK.
  - A decode function (4-bit BCD -> 7 segments).
  - BCD_W=4.
- Sub-module `bcd_digit_cnt`:
  - Ports: 4-bit digit, inc, dec, load, load_val.
  - Outputs: carry and borrow.
  - Instantiated NUM_DIGITS times with a generate loop; the top level chains carry and borrow between instances.

Test Plan:
- Reset check (NUM_DIGITS=2, TICK_COUNT=4, SCAN_COUNT=2): hold reset for 3 cycles, then release with en=0 -> count_out=8'h00, digit_sel=2'b01, led_out=0111111, wrap=0, io_oeb=0.
- Up count and prescaler period: en=1, up_down=1 for 400 cycles:
  - count_out steps every 4 cycles: 8'h09 -> 8'h10 carry observed.
  - Reaches 8'h99, then 8'h00 with wrap high for exactly 1 cycle at cycle 400.
  - en=0 freezes the value.
- Down count and borrow: load 8'h10, then up_down=0 -> after 1 tick count_out=8'h09; from 8'h00 one tick gives 8'h99 with a wrap pulse.
- Load priority and sanitising: assert load with load_value=8'h5C in the same cycle as a tick -> count_out=8'h50 next cycle, no increment, wrap=0, and the next tick comes 4 cycles later.
- Scan and blanking: count_out=8'h07:
  - blank_lz=0: digit_sel alternates 01/10 every 2 cycles, with led_out=0000111 / 0111111.
  - blank_lz=1: the digit-1 slot shows 0000000 and digit 0 still shows 0000111.
- Reset mid-operation: assert reset while count_out=8'h42, the scan index is 1 and the prescaler is 2 -> next cycle all outputs equal the reset values, and the first tick after release comes exactly 4 cycles later.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and glyph decoder for the multi-digit
// seven-segment counter display.
package seven_seg_pkg;

    localparam int BCD_W = 4;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111100;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_segment_counter_mux_digit.sv
// One BCD decade of the display counter; carry/borrow flag the
// step that rolls this digit over so the next decade can follow.
module bcd_digit_cnt
    import seven_seg_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] digit,
    output logic             carry,
    output logic             borrow
);

    logic [BCD_W-1:0] r_digit;

    assign digit  = r_digit;
    assign carry  = inc && (r_digit == 4'd9);
    assign borrow = dec && (r_digit == 4'd0);

    // Load beats stepping; non-decimal load values become 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= (load_val > 4'd9) ? 4'd0 : load_val;
        end else if (inc) begin
            r_digit <= carry ? 4'd0 : r_digit + 4'd1;
        end else if (dec) begin
            r_digit <= borrow ? 4'd9 : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/seven_segment_counter_mux.sv
// N-digit up/down BCD counter with prescaler, driving a
// time-multiplexed common-segment seven-segment display.
module seven_segment_counter_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_COUNT = 16000000,
    parameter int SCAN_COUNT = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        up_down,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    input  logic                        blank_lz,
    output logic [BCD_W*NUM_DIGITS-1:0] count_out,
    output logic                        wrap,
    output logic [6:0]                  led_out,
    output logic [NUM_DIGITS-1:0]       digit_sel,
    output logic [6+NUM_DIGITS:0]       io_oeb
);

    localparam int PRE_W  = $clog2(TICK_COUNT);
    localparam int SCAN_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRE_W-1:0]            r_pre;
    logic                        r_wrap;
    logic [SCAN_W-1:0]           r_scan;
    logic [IDX_W-1:0]            r_idx;
    logic [NUM_DIGITS-1:0]       r_sel;
    logic [6:0]                  r_led;

    logic                        w_tick;
    logic [NUM_DIGITS-1:0]       w_inc;
    logic [NUM_DIGITS-1:0]       w_dec;
    logic [NUM_DIGITS-1:0]       w_carry;
    logic [NUM_DIGITS-1:0]       w_borrow;
    logic [BCD_W*NUM_DIGITS-1:0] w_count;
    logic [NUM_DIGITS-1:0]       w_zero_hi;
    logic                        w_scan_end;
    logic [IDX_W-1:0]            w_idx_next;
    logic [BCD_W-1:0]            w_digit_val;
    logic                        w_blank;
    logic [6:0]                  w_led_next;
    logic [NUM_DIGITS-1:0]       w_sel_next;

    assign w_tick    = en && (r_pre == PRE_W'(TICK_COUNT - 1));
    assign count_out = w_count;
    assign wrap      = r_wrap;
    assign led_out   = r_led;
    assign digit_sel = r_sel;
    assign io_oeb    = '0;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        if (k == 0) begin : g_lsd
            assign w_inc[k] = w_tick && up_down;
            assign w_dec[k] = w_tick && !up_down;
        end else begin : g_upper
            assign w_inc[k] = w_carry[k-1];
            assign w_dec[k] = w_borrow[k-1];
        end

        bcd_digit_cnt u_digit (
            .clk      (clk),
            .reset    (reset),
            .inc      (w_inc[k]),
            .dec      (w_dec[k]),
            .load     (load),
            .load_val (load_value[k*BCD_W +: BCD_W]),
            .digit    (w_count[k*BCD_W +: BCD_W]),
            .carry    (w_carry[k]),
            .borrow   (w_borrow[k])
        );
    end

    // Prescaler: period TICK_COUNT while enabled, cleared by load
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    // Wrap pulse is registered alongside the digit that rolled over
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= !load && w_tick &&
                      (up_down ? w_carry[NUM_DIGITS-1]
                               : w_borrow[NUM_DIGITS-1]);
        end
    end

    // Digit k is a leading zero if it and every higher digit are 0
    always_comb begin
        w_zero_hi = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            for (int j = k; j < NUM_DIGITS; j++) begin
                if (w_count[j*BCD_W +: BCD_W] != '0) begin
                    w_zero_hi[k] = 1'b0;
                end
            end
        end
    end

    // Next scan slot and its glyph, computed together to avoid ghosting
    always_comb begin
        w_scan_end  = (r_scan == SCAN_W'(SCAN_COUNT - 1));
        w_idx_next  = r_idx;
        if (w_scan_end) begin
            w_idx_next = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                           : r_idx + 1'b1;
        end
        w_digit_val = w_count[int'(w_idx_next)*BCD_W +: BCD_W];
        w_blank     = blank_lz && (w_idx_next != '0) &&
                      w_zero_hi[w_idx_next];
        w_led_next  = w_blank ? SEG_BLANK : seg_decode(w_digit_val);
        w_sel_next  = NUM_DIGITS'(1) << w_idx_next;
    end

    // Free-running scan; select and segments update on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_sel  <= NUM_DIGITS'(1);
            r_led  <= SEG_0;
        end else begin
            r_scan <= w_scan_end ? '0 : r_scan + 1'b1;
            r_idx  <= w_idx_next;
            r_sel  <= w_sel_next;
            r_led  <= w_led_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench for seven_segment_counter_mux with 2 digits,
// a 4-cycle tick and a 2-cycle scan slot.
module tb_seven_segment_counter_mux;

    localparam int ND = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          up_down;
    logic          load;
    logic [4*ND-1:0] load_value;
    logic          blank_lz;
    logic [4*ND-1:0] count_out;
    logic          wrap;
    logic [6:0]    led_out;
    logic [ND-1:0] digit_sel;
    logic [6+ND:0] io_oeb;

    int n_checks = 0;
    int n_errors = 0;

    seven_segment_counter_mux #(
        .NUM_DIGITS (ND),
        .TICK_COUNT (4),
        .SCAN_COUNT (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .blank_lz   (blank_lz),
        .count_out  (count_out),
        .wrap       (wrap),
        .led_out    (led_out),
        .digit_sel  (digit_sel),
        .io_oeb     (io_oeb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b0;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = '0;
        blank_lz   = 1'b0;

        // Reset state
        step(3);
        reset = 1'b0;
        check("rst_count", count_out, 8'h00);
        check("rst_sel", digit_sel, 2'b01);
        check("rst_led", led_out, 7'b0111111);
        check("rst_wrap", wrap, 1'b0);
        check("rst_oeb", io_oeb, 9'h000);

        // Up count across carry and full wrap
        en = 1'b1;
        for (int c = 1; c <= 401; c++) begin
            step(1);
            if (c == 39) check("up_09", count_out, 8'h09);
            if (c == 40) check("up_10", count_out, 8'h10);
            if (c == 396) begin
                check("up_99", count_out, 8'h99);
                check("up_99_wrap", wrap, 1'b0);
            end
            if (c == 400) begin
                check("up_wrap_cnt", count_out, 8'h00);
                check("up_wrap", wrap, 1'b1);
            end
            if (c == 401) check("up_wrap_off", wrap, 1'b0);
        end
        en = 1'b0;
        step(8);
        check("en_freeze", count_out, 8'h00);

        // Down count with borrow and wrap
        load = 1'b1; load_value = 8'h10;
        step(1);
        load = 1'b0;
        check("ld_10", count_out, 8'h10);
        up_down = 1'b0; en = 1'b1;
        step(4);
        check("dn_09", count_out, 8'h09);
        load = 1'b1; load_value = 8'h00;
        step(1);
        load = 1'b0;
        check("ld_00", count_out, 8'h00);
        check("ld_00_wrap", wrap, 1'b0);
        step(4);
        check("dn_99", count_out, 8'h99);
        check("dn_wrap", wrap, 1'b1);
        step(1);
        check("dn_wrap_off", wrap, 1'b0);

        // Load coinciding with a tick, digit sanitising
        up_down = 1'b1;
        step(2);
        check("pre_ld", count_out, 8'h99);
        load = 1'b1; load_value = 8'h5C;
        step(1);
        load = 1'b0;
        check("ld_5c", count_out, 8'h50);
        check("ld_5c_wrap", wrap, 1'b0);
        step(3);
        check("ld_hold", count_out, 8'h50);
        step(1);
        check("ld_tick", count_out, 8'h51);

        // Scan and leading-zero blanking
        en = 1'b0; reset = 1'b1;
        step(1);
        reset = 1'b0; load = 1'b1; load_value = 8'h07;
        step(1);
        load = 1'b0;
        step(1);
        check("sc_e2_sel", digit_sel, 2'b10);
        check("sc_e2_led", led_out, 7'b0111111);
        step(2);
        check("sc_e4_sel", digit_sel, 2'b01);
        check("sc_e4_led", led_out, 7'b0000111);
        step(1);
        check("sc_e5_sel", digit_sel, 2'b01);
        check("sc_e5_led", led_out, 7'b0000111);
        step(1);
        check("sc_e6_sel", digit_sel, 2'b10);
        check("sc_e6_led", led_out, 7'b0111111);
        blank_lz = 1'b1;
        step(1);
        check("bl_sel", digit_sel, 2'b10);
        check("bl_led", led_out, 7'b0000000);
        step(1);
        check("bl_d0_sel", digit_sel, 2'b01);
        check("bl_d0_led", led_out, 7'b0000111);

        // Reset mid-scan and mid-prescale, overriding load
        blank_lz = 1'b0; reset = 1'b1;
        step(1);
        reset = 1'b0; load = 1'b1; load_value = 8'h42;
        step(1);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        step(2);
        check("mid_count", count_out, 8'h42);
        check("mid_sel", digit_sel, 2'b10);
        check("mid_led", led_out, 7'b1100110);
        reset = 1'b1; load = 1'b1; load_value = 8'h99;
        step(1);
        check("mr_count", count_out, 8'h00);
        check("mr_sel", digit_sel, 2'b01);
        check("mr_led", led_out, 7'b0111111);
        check("mr_wrap", wrap, 1'b0);
        reset = 1'b0; load = 1'b0;
        step(3);
        check("mr_hold", count_out, 8'h00);
        step(1);
        check("mr_tick", count_out, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
